// File: rtl/rtc_pkg.sv
// rtc_pkg: BCD time layout shared by the RTC stopwatch and countdown.
// Holds the digit field positions, widths and borrow maxima.
package rtc_pkg;

    localparam int BCD_W = 31;
    localparam int NDIG  = 8;

    // Field LSB positions within the HH:MM:SS.cc word
    localparam int HUN_LSB  = 0;
    localparam int TEN_LSB  = 4;
    localparam int SECU_LSB = 8;
    localparam int SECT_LSB = 12;
    localparam int MINU_LSB = 16;
    localparam int MINT_LSB = 20;
    localparam int HRU_LSB  = 24;
    localparam int HRT_LSB  = 28;

    // Value a digit takes when it borrows from the digit above
    localparam int DIG_MAX_UNIT  = 9;
    localparam int DIG_MAX_TEN60 = 5;
    localparam int DIG_MAX_HRTEN = 7;

    localparam int DIG_LSB [NDIG] = '{
        HUN_LSB, TEN_LSB, SECU_LSB, SECT_LSB,
        MINU_LSB, MINT_LSB, HRU_LSB, HRT_LSB
    };

    localparam int DIG_W [NDIG] = '{4, 4, 4, 3, 4, 3, 4, 3};

    localparam int DIG_MAX [NDIG] = '{
        DIG_MAX_UNIT, DIG_MAX_UNIT, DIG_MAX_UNIT, DIG_MAX_TEN60,
        DIG_MAX_UNIT, DIG_MAX_TEN60, DIG_MAX_UNIT, DIG_MAX_HRTEN
    };

    // Bits 15 and 23 are padding between the seconds/minutes/hours fields
    localparam logic [BCD_W-1:0] BCD_PAD_MASK = 31'h7F7F_7FFF;

    function automatic logic [BCD_W-1:0] bcd_clean(
        input logic [BCD_W-1:0] v
    );
        return v & BCD_PAD_MASK;
    endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// bcd_digit_dec: one BCD digit of a borrow-chained down counter.
// Ports: i_digit/i_borrow in; o_next (next digit) and o_borrow out.
module bcd_digit_dec #(
    parameter int W   = 4,
    parameter int MAX = 9
) (
    input  logic [W-1:0] i_digit,
    input  logic         i_borrow,
    output logic [W-1:0] o_next,
    output logic         o_borrow
);

    logic zero;

    assign zero     = (i_digit == '0);
    assign o_borrow = i_borrow & zero;

    // Digit only moves when every lower digit is zero (borrow in);
    // out-of-range codes simply count down like any other value.
    always_comb begin
        o_next = i_digit;
        if (i_borrow) begin
            o_next = zero ? W'(MAX) : i_digit - 1'b1;
        end
    end

endmodule

// File: rtl/rtccountdown.sv
// rtccountdown: BCD HH:MM:SS.cc countdown timer ticking every 10 ms.
// Ports: i_clk, i_reset_n, i_ckstep, i_load/i_value, i_start, i_stop,
//   i_ack in; o_value, o_running, o_alarm, o_int out.
module rtccountdown
    import rtc_pkg::*;
#(
    parameter bit OPT_AUTORELOAD = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [31:0]      i_ckstep,
    input  logic             i_load,
    input  logic [BCD_W-1:0] i_value,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_ack,
    output logic [BCD_W-1:0] o_value,
    output logic             o_running,
    output logic             o_alarm,
    output logic             o_int
);

    logic [38:0]      step_q, step_d;
    logic [47:0]      acc_q, acc_d;
    logic [48:0]      acc_sum;
    logic [BCD_W-1:0] cnt_q, cnt_d;
    logic [BCD_W-1:0] rld_q, rld_d;
    logic [BCD_W-1:0] nxt_q, nxt_d;
    logic             run_q, run_d;
    logic             alarm_q, alarm_d;
    logic             int_q, int_d;
    logic             tick, cnt_zero, expire, start_ok;
    logic [NDIG:0]    borrow;
    logic             unused_borrow;

    // 100 * per-clock step: the 48-bit accumulator then wraps
    // every 10 ms instead of every second.
    assign step_d   = 39'(i_ckstep) * 39'd100;
    assign acc_sum  = {1'b0, acc_q} + {10'd0, step_q};
    assign tick     = run_q & acc_sum[48];
    assign cnt_zero = (cnt_q == '0);
    assign expire   = tick & (cnt_q == 31'd1);
    assign start_ok = i_start & ~run_q & ~cnt_zero;

    // Borrow chain: hundredths always decrement.
    assign borrow[0] = 1'b1;

    for (genvar g = 0; g < NDIG; g++) begin : g_dig
        bcd_digit_dec #(
            .W   (DIG_W[g]),
            .MAX (DIG_MAX[g])
        ) u_dig (
            .i_digit  (cnt_q[DIG_LSB[g] +: DIG_W[g]]),
            .i_borrow (borrow[g]),
            .o_next   (nxt_d[DIG_LSB[g] +: DIG_W[g]]),
            .o_borrow (borrow[g+1])
        );
    end

    assign nxt_d[15]     = 1'b0;
    assign nxt_d[23]     = 1'b0;
    assign unused_borrow = borrow[NDIG];

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        rld_d   = rld_q;
        run_d   = run_q;
        alarm_d = alarm_q;
        int_d   = 1'b0;

        // Expiry below re-sets the alarm, so it wins over ack.
        if (i_ack) begin
            alarm_d = 1'b0;
        end

        if (i_load) begin
            cnt_d   = bcd_clean(i_value);
            rld_d   = bcd_clean(i_value);
            run_d   = 1'b0;
            alarm_d = 1'b0;
            acc_d   = '0;
        end else if (i_stop) begin
            run_d = 1'b0;
        end else if (start_ok) begin
            // Fresh start so the first period is a full 10 ms
            run_d = 1'b1;
            acc_d = '0;
        end else if (run_q) begin
            acc_d = acc_sum[47:0];
            if (expire) begin
                int_d   = 1'b1;
                alarm_d = 1'b1;
                if (OPT_AUTORELOAD) begin
                    cnt_d = rld_q;
                    run_d = |rld_q;
                end else begin
                    cnt_d = '0;
                    run_d = 1'b0;
                end
            end else if (tick) begin
                cnt_d = nxt_q;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            step_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            rld_q   <= '0;
            nxt_q   <= '0;
            run_q   <= 1'b0;
            alarm_q <= 1'b0;
            int_q   <= 1'b0;
        end else begin
            step_q  <= step_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            rld_q   <= rld_d;
            nxt_q   <= nxt_d;
            run_q   <= run_d;
            alarm_q <= alarm_d;
            int_q   <= int_d;
        end
    end

    assign o_value   = cnt_q;
    assign o_running = run_q;
    assign o_alarm   = alarm_q;
    assign o_int     = int_q;

endmodule

// File: tb/tb_rtccountdown.sv
// tb_rtccountdown: bench for rtccountdown, both reload options side by side.
// Model counts in plain centiseconds and converts to BCD for comparison.
module tb_rtccountdown;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ckstep;
    logic        ld, st, sp, ak;
    logic [30:0] val;
    logic [30:0] ov   [2];
    logic        orun [2];
    logic        oal  [2];
    logic        oint [2];

    always #5 clk = ~clk;

    rtccountdown #(.OPT_AUTORELOAD(1'b0)) u_dut0 (
        .i_clk(clk), .i_reset_n(rst_n), .i_ckstep(ckstep),
        .i_load(ld), .i_value(val), .i_start(st), .i_stop(sp),
        .i_ack(ak), .o_value(ov[0]), .o_running(orun[0]),
        .o_alarm(oal[0]), .o_int(oint[0])
    );

    rtccountdown #(.OPT_AUTORELOAD(1'b1)) u_dut1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_ckstep(ckstep),
        .i_load(ld), .i_value(val), .i_start(st), .i_stop(sp),
        .i_ack(ak), .o_value(ov[1]), .o_running(orun[1]),
        .o_alarm(oal[1]), .o_int(oint[1])
    );

    localparam longint TWO48 = 64'h0001_0000_0000_0000;

    int tests = 0;
    int fails = 0;
    int int_cnt [2];

    longint m_cs  [2];
    longint m_rl  [2];
    longint m_acc [2];
    longint m_step;
    bit     m_run [2];
    bit     m_al  [2];
    bit     m_int [2];
    bit     m_ok  [2];

    typedef struct {
        logic [30:0] ldv;
        logic [30:0] exp_ld;
        logic [30:0] exp_nx;
    } vec_t;

    vec_t tbl [9];

    function automatic bit bcd_ok(input logic [30:0] v);
        return v[3:0] <= 9 && v[7:4] <= 9 && v[11:8] <= 9 &&
               v[14:12] <= 5 && v[19:16] <= 9 && v[22:20] <= 5 &&
               v[27:24] <= 9;
    endfunction

    function automatic longint bcd2cs(input logic [30:0] v);
        longint h, m, s, c;
        h = longint'(v[30:28]) * 10 + longint'(v[27:24]);
        m = longint'(v[22:20]) * 10 + longint'(v[19:16]);
        s = longint'(v[14:12]) * 10 + longint'(v[11:8]);
        c = longint'(v[7:4]) * 10 + longint'(v[3:0]);
        return ((h * 60 + m) * 60 + s) * 100 + c;
    endfunction

    function automatic logic [30:0] cs2bcd(input longint cs);
        longint c, s, m, h;
        logic [30:0] r;
        c = cs % 100;
        s = (cs / 100) % 60;
        m = (cs / 6000) % 60;
        h = cs / 360000;
        r = '0;
        r[3:0]   = 4'(c % 10);
        r[7:4]   = 4'(c / 10);
        r[11:8]  = 4'(s % 10);
        r[14:12] = 3'(s / 10);
        r[19:16] = 4'(m % 10);
        r[22:20] = 3'(m / 10);
        r[27:24] = 4'(h % 10);
        r[30:28] = 3'(h / 10);
        return r;
    endfunction

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cs[k] = 0; m_rl[k] = 0; m_acc[k] = 0;
            m_run[k] = 0; m_al[k] = 0; m_int[k] = 0; m_ok[k] = 1;
        end
        m_step = 0;
    endtask

    // One clock edge of the reference timer
    task automatic model_update();
        longint sum;
        bit tick, fire;
        logic [30:0] v;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            sum  = m_acc[k] + m_step;
            tick = m_run[k] && (sum >= TWO48);
            fire = 0;
            m_int[k] = 0;
            if (ld) begin
                v = val;
                v[15] = 1'b0;
                v[23] = 1'b0;
                m_ok[k]  = bcd_ok(v);
                m_cs[k]  = bcd2cs(v);
                m_rl[k]  = m_cs[k];
                m_run[k] = 0;
                m_al[k]  = 0;
                m_acc[k] = 0;
            end else begin
                if (sp) begin
                    m_run[k] = 0;
                end else if (st && !m_run[k]) begin
                    if (m_cs[k] != 0) begin
                        m_run[k] = 1;
                        m_acc[k] = 0;
                    end
                end else if (m_run[k]) begin
                    m_acc[k] = sum % TWO48;
                    if (tick) begin
                        m_cs[k] = m_cs[k] - 1;
                        if (m_cs[k] == 0) begin
                            fire = 1;
                            m_int[k] = 1;
                            if (k == 1 && m_rl[k] != 0) m_cs[k] = m_rl[k];
                            else m_run[k] = 0;
                        end
                    end
                end
                if (fire) m_al[k] = 1;
                else if (ak) m_al[k] = 0;
            end
        end
        m_step = 100 * longint'(ckstep);
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            if (oint[k]) int_cnt[k]++;
            if (m_ok[k]) begin
                chk($sformatf("dut%0d model value", k), ov[k],
                    cs2bcd(m_cs[k]));
                chk($sformatf("dut%0d model running", k), orun[k], m_run[k]);
                chk($sformatf("dut%0d model alarm", k), oal[k], m_al[k]);
                chk($sformatf("dut%0d model int", k), oint[k], m_int[k]);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic drive(input bit l, input logic [30:0] v, input bit s,
                         input bit p, input bit a);
        ld = l; val = v; st = s; sp = p; ak = a;
        cycle();
        ld = 0; st = 0; sp = 0; ak = 0;
    endtask

    task automatic wait_change(input int k, input int bound,
                               output int cyc);
        logic [30:0] old;
        old = ov[k];
        cyc = 0;
        while (ov[k] == old && cyc < bound) begin
            cycle();
            cyc++;
        end
        tests++;
        if (ov[k] == old) begin
            fails++;
            $display("FAIL dut%0d tick timeout: value %0h after %0d cycles",
                     k, old, cyc);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, i0, i1, r;

        tbl[0] = '{31'h00010000, 31'h00010000, 31'h00005999};
        tbl[1] = '{31'h01000000, 31'h01000000, 31'h00595999};
        tbl[2] = '{31'h10000000, 31'h10000000, 31'h09595999};
        tbl[3] = '{31'h00000100, 31'h00000100, 31'h00000099};
        tbl[4] = '{31'h00001000, 31'h00001000, 31'h00000999};
        tbl[5] = '{31'h00100000, 31'h00100000, 31'h00095999};
        tbl[6] = '{31'h0000000C, 31'h0000000C, 31'h0000000B};
        tbl[7] = '{31'h00808005, 31'h00000005, 31'h00000004};
        tbl[8] = '{31'h00000A00, 31'h00000A00, 31'h00000999};

        int_cnt[0] = 0;
        int_cnt[1] = 0;
        rst_n = 0; ckstep = 32'hFFFF_FFFF;
        ld = 0; st = 0; sp = 0; ak = 0; val = '0;
        model_reset();
        idle(3);
        rst_n = 1;
        idle(2);
        for (int k = 0; k < 2; k++) begin
            chk("reset value", ov[k], 0);
            chk("reset running", orun[k], 0);
            chk("reset alarm", oal[k], 0);
            chk("reset int", oint[k], 0);
        end

        // Basic countdown 3,2,1,0
        drive(1, 31'h3, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        i0 = int_cnt[0];
        wait_change(0, 1000, c);
        chk("cd first value", ov[0], 2);
        chk("cd first spacing", c, 656);
        wait_change(0, 1000, c);
        chk("cd second value", ov[0], 1);
        chk("cd spacing ok", (c == 655 || c == 656), 1);
        wait_change(0, 1000, c);
        chk("cd zero value", ov[0], 0);
        chk("cd int pulse", oint[0], 1);
        chk("cd int count", int_cnt[0] - i0, 1);
        chk("cd alarm", oal[0], 1);
        chk("cd stopped", orun[0], 0);
        chk("reload value", ov[1], 3);
        chk("reload running", orun[1], 1);
        cycle();
        chk("cd int one cycle", oint[0], 0);
        drive(1, 0, 0, 0, 0);

        // Start while already running keeps the accumulator phase
        drive(1, 31'h3, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        idle(300);
        drive(0, 0, 1, 0, 0);
        wait_change(0, 1000, c);
        chk("restart no clear", c, 355);
        drive(1, 0, 0, 0, 0);

        // Table of loads and single borrow steps
        foreach (tbl[i]) begin
            drive(1, tbl[i].ldv, 0, 0, 0);
            chk($sformatf("tbl%0d load", i), ov[0], tbl[i].exp_ld);
            chk($sformatf("tbl%0d idle", i), orun[0], 0);
            drive(0, 0, 1, 0, 0);
            wait_change(0, 1000, c);
            chk($sformatf("tbl%0d step", i), ov[0], tbl[i].exp_nx);
            drive(0, 0, 0, 1, 0);
        end

        // Pause and resume
        drive(1, 31'h50, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        wait_change(0, 1000, c);
        chk("pause pre", ov[0], 31'h49);
        drive(0, 0, 0, 1, 0);
        chk("pause stopped", orun[0], 0);
        idle(5000);
        chk("pause hold", ov[0], 31'h49);
        drive(0, 0, 1, 0, 0);
        chk("resume running", orun[0], 1);
        wait_change(0, 1000, c);
        chk("resume value", ov[0], 31'h48);
        chk("resume full period", c, 656);

        // Start with zero count is ignored
        drive(1, 0, 0, 0, 0);
        i0 = int_cnt[0];
        drive(0, 0, 1, 0, 0);
        idle(20);
        chk("zero start run0", orun[0], 0);
        chk("zero start run1", orun[1], 0);
        chk("zero start int", int_cnt[0] - i0, 0);
        chk("zero start alarm", oal[0], 0);

        // Auto-reload keeps firing every two ticks
        drive(1, 31'h2, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        i1 = int_cnt[1];
        for (int t = 0; t < 6; t++) begin
            wait_change(1, 1000, c);
            chk($sformatf("auto value %0d", t), ov[1], (t % 2) ? 2 : 1);
            chk($sformatf("auto running %0d", t), orun[1], 1);
            chk($sformatf("auto ints %0d", t), int_cnt[1] - i1, (t + 1) / 2);
        end
        drive(1, 0, 0, 0, 0);

        // Ack held through expiry: set wins, then ack clears
        drive(1, 31'h1, 0, 0, 0);
        ak = 1; st = 1;
        cycle();
        st = 0;
        wait_change(0, 1000, c);
        chk("ack vs expiry alarm", oal[0], 1);
        chk("ack vs expiry int", oint[0], 1);
        cycle();
        chk("ack clears alarm", oal[0], 0);
        ak = 0;

        // Load beats start, stop beats start
        drive(1, 31'h5, 1, 0, 0);
        chk("load+start value", ov[0], 5);
        chk("load+start stopped", orun[0], 0);
        drive(0, 0, 1, 1, 0);
        chk("stop+start idle", orun[0], 0);
        drive(0, 0, 1, 0, 0);
        idle(10);
        chk("start runs", orun[0], 1);
        drive(0, 0, 1, 1, 0);
        chk("stop+start running", orun[0], 0);

        // Load while running: stops, no interrupt
        drive(0, 0, 1, 0, 0);
        idle(100);
        i0 = int_cnt[0];
        drive(1, 31'h7, 0, 0, 0);
        idle(10);
        chk("load running value", ov[0], 7);
        chk("load running stop", orun[0], 0);
        chk("load running int", int_cnt[0] - i0, 0);

        // Asynchronous reset between edges
        drive(1, 31'h2, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        idle(300);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("async value", ov[k], 0);
            chk("async running", orun[k], 0);
            chk("async alarm", oal[k], 0);
            chk("async int", oint[k], 0);
        end
        idle(2);
        rst_n = 1;
        i0 = int_cnt[0];
        i1 = int_cnt[1];
        idle(2000);
        chk("post reset int0", int_cnt[0] - i0, 0);
        chk("post reset int1", int_cnt[1] - i1, 0);
        chk("post reset run", orun[0], 0);

        // Randomized traffic against the model
        for (int n = 0; n < 60; n++) begin
            ckstep = $urandom | 32'hC000_0000;
            r = $urandom_range(0, 9);
            if (r <= 2) begin
                drive(1, cs2bcd(longint'($urandom_range(0, 5))), 0, 0, 0);
            end else if (r == 3) begin
                drive(1, cs2bcd(longint'($urandom_range(0, 28799999))),
                      0, 0, 0);
            end else if (r == 4 || r == 5 || r == 9) begin
                drive(0, 0, 1, 0, 0);
            end else if (r == 6) begin
                drive(0, 0, 0, 1, 0);
            end else if (r == 7) begin
                drive(0, 0, 0, 0, 1);
            end else begin
                drive(1'($urandom), cs2bcd(longint'($urandom_range(0, 4))),
                      1'($urandom), 1'($urandom), 1'($urandom));
            end
            idle($urandom_range(1, 900));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rtccountdown.md
Name: rtccountdown

Overview:
BCD countdown timer; the count-down counterpart of the RTC stopwatch.
- Loaded with an HH:MM:SS.cc value in the same BCD layout the stopwatch produces.
- Decrements once per 10 ms from the RTC's fractional-second step.
- Raises a sticky alarm and a one-cycle interrupt on reaching zero.
- Sits beside the stopwatch inside the RTC core, under the same wishbone register decode.

Parameters:
OPT_AUTORELOAD, 0, 1 = on expiry reload last loaded value and keep running; 0 = stop at zero

Ports:
i_clk  in  1  system clock
i_reset_n  in  1  asynchronous, active-low reset
i_ckstep  in  32  low 32 bits of 48-bit per-clock step; the 48-bit accumulator rolls over once per second
i_load  in  1  load i_value into counter and reload register
i_value  in  31  BCD load value
i_start  in  1  start countdown
i_stop  in  1  stop/pause countdown
i_ack  in  1  clear sticky alarm
o_value  out  31  current BCD remaining time
o_running  out  1  countdown active
o_alarm  out  1  sticky expiry flag
o_int  out  1  one-cycle pulse on expiry

Behaviour:
- BCD layout of o_value / i_value:
  - [3:0] hundredths; [7:4] tenths
  - [11:8] sec units; [14:12] sec tens (0-5); [15] = 0
  - [19:16] min units; [22:20] min tens (0-5); [23] = 0
  - [27:24] hour units; [30:28] hour tens (0-7)
- Reset (async assert, sync-released use): all registers 0; o_value=0, o_running=0, o_alarm=0, o_int=0.
- Tick generation:
  - step register = 100*i_ckstep, 39 bits, registered (1-cycle latency).
  - 48-bit accumulator adds step each cycle while running; carry out of bit 47 = 10 ms tick.
  - Ticks are at least 655 cycles apart for any i_ckstep.
  - Accumulator clears on i_load and on i_start-from-stopped, so the first period is a full 10 ms.
- Decrement:
  - A registered next_value is computed every cycle from the counter (1-cycle latency).
  - Each digit decrements by 1 when all lower digits are 0; otherwise it holds.
  - On borrow, a digit becomes its max: 9 for units and tenths, 5 for sec/min tens, 7 for hour tens.
  - The counter takes next_value on a tick while running.
- Load:
  - Bits 15 and 23 are forced to 0.
  - Out-of-range digits (e.g. 0xC) load as given and decrement normally; no clamping.
  - Load stops the timer, clears o_alarm, and stores the value in the reload register.
- Start:
  - Counter == 0 → start ignored (o_running stays 0, no alarm).
  - Otherwise o_running=1 on the next cycle.
- Expiry = tick while running with counter == 0x00000001 (the last decrement reaches 0):
  - o_int=1 for that one cycle; o_alarm=1 (sticky).
  - OPT_AUTORELOAD=0: counter=0, o_running=0.
  - OPT_AUTORELOAD=1: counter=reload value, o_running stays 1; if reload value is 0, o_running=0.
- Priority (same cycle): i_reset_n > i_load > i_stop > i_start.
- Expiry set beats i_ack in the same cycle (alarm remains 1).
- i_stop: o_running=0 next cycle; counter and accumulator hold (pause); a later i_start resumes with the accumulator cleared.
- i_load while running: loads and stops; no o_int.
- i_start while already running: no effect, accumulator not cleared.

Decomposition:
- Package rtc_pkg: BCD field position constants (shared with the stopwatch) and digit max constants (9, 5, 7).
- Sub-module bcd_digit_dec: one digit, with max-value parameter, borrow-in, borrow-out and next digit; instantiated 8 times.

Test Plan:
- Load and countdown: i_ckstep=32'hFFFFFFFF, i_load 0x00000003, i_start → o_value steps 3,2,1,0 about every 655 cycles; o_int one pulse; o_alarm=1; o_running=0.
- Borrow chains:
  - Load 0x00010000 (1 min), run one tick → o_value=0x00005999.
  - Load 0x01000000 (1 h), run one tick → o_value=0x00595999.
- Pause and zero start:
  - i_stop mid-count → o_value constant for 5000 cycles; i_start resumes.
  - Load 0 then i_start → o_running stays 0, no o_int.
- Auto-reload: OPT_AUTORELOAD=1, load 0x00000002, start → o_int every 2 ticks; o_running stays 1; o_value reloads to 2.
- Simultaneous events:
  - i_ack on the expiry cycle → o_alarm=1.
  - i_load with i_start → loaded and stopped.
  - i_stop with i_start → stopped.
- Async reset mid-count: drop i_reset_n between clock edges → all outputs 0 immediately; no o_int after release.
